// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package decoder_pkg;

    localparam int unsigned MAX_SEL_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    // Dwell counter width: max(1, clog2(dwell)).
    function automatic int unsigned dwell_cnt_w(input int unsigned dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W to 2**SEL_W one-hot decode.
module decoder_onehot #(
    parameter int unsigned SEL_W = 3
) (
    input  logic [SEL_W-1:0]      idx,
    output logic [2**SEL_W-1:0]   lines
);

    always_comb begin
        lines      = '0;
        lines[idx] = 1'b1;
    end

endmodule

// File: rtl/decoder_scan_n_to_2n.sv
// Registered binary-to-one-hot decoder with load/hold and an optional scan sequencer.
// Scan mode, dwell counter and wrap pulse are built only when DECODER_SCAN_EN is defined.
module decoder_scan_n_to_2n
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic                  scan,
    input  logic [SEL_W-1:0]      in_lines,
    output logic [2**SEL_W-1:0]   out_lines,
    output logic [SEL_W-1:0]      cur_idx,
    output logic                  wrap
);

    localparam int unsigned OUT_N = 2**SEL_W;

    if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_bad_sel_w
        $error("SEL_W must be in 1..%0d", MAX_SEL_W);
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("DWELL must be at least 1");
    end

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   idx_nxt;
    logic [OUT_N-1:0]   dec_lines;
    logic [OUT_N-1:0]   lines_nxt;

    // Decode the index being registered so out_lines and cur_idx update together.
    decoder_onehot #(.SEL_W(SEL_W)) u_onehot (
        .idx   (idx_nxt),
        .lines (dec_lines)
    );

`ifdef DECODER_SCAN_EN
    localparam int unsigned CNT_W = dwell_cnt_w(DWELL);

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               wrap_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_idx   <= '0;
            cnt       <= '0;
            out_lines <= '0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_idx   <= idx_nxt;
            cnt       <= cnt_nxt;
            out_lines <= lines_nxt;
            wrap      <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = cur_idx;
        cnt_nxt   = cnt;
        wrap_nxt  = 1'b0;
        lines_nxt = '0;

        if (load) begin
            idx_nxt   = in_lines;
            cnt_nxt   = '0;
            state_nxt = scan ? SCAN : HOLD;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (scan) begin
                        state_nxt = SCAN;
                        cnt_nxt   = '0;
                    end
                end
                SCAN: begin
                    if (!scan) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(DWELL - 1)) begin
                        cnt_nxt  = '0;
                        idx_nxt  = cur_idx + SEL_W'(1);
                        wrap_nxt = (cur_idx == SEL_W'(OUT_N - 1));
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (en && state_nxt != IDLE) begin
            lines_nxt = dec_lines;
        end
    end
`else
    logic unused_scan;
    assign unused_scan = scan;
    assign wrap        = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_idx   <= '0;
            out_lines <= '0;
        end else begin
            state     <= state_nxt;
            cur_idx   <= idx_nxt;
            out_lines <= lines_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = cur_idx;
        lines_nxt = '0;

        if (load) begin
            idx_nxt   = in_lines;
            state_nxt = HOLD;
        end

        if (en && state_nxt != IDLE) begin
            lines_nxt = dec_lines;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_scan_n_to_2n.sv
// Scoreboard bench for decoder_scan_n_to_2n: two instances (DWELL=2 and DWELL=1) share stimulus.
module tb_decoder_scan_n_to_2n;

`ifdef DECODER_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       scan = 1'b0;
    logic [2:0] in_lines = 3'd0;

    logic [7:0] out_a, out_b;
    logic [2:0] idx_a, idx_b;
    logic       wrap_a, wrap_b;

    always #5 clk = ~clk;

    decoder_scan_n_to_2n #(.SEL_W(3), .DWELL(2)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .scan(scan),
        .in_lines(in_lines), .out_lines(out_a), .cur_idx(idx_a), .wrap(wrap_a)
    );

    decoder_scan_n_to_2n #(.SEL_W(3), .DWELL(1)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .scan(scan),
        .in_lines(in_lines), .out_lines(out_b), .cur_idx(idx_b), .wrap(wrap_b)
    );

    typedef struct {
        int lines;
        int idx;
        int wrap;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int m_state[2];
    int m_idx[2];
    int m_cnt[2];
    int dwell[2] = '{2, 1};

    int n_checks = 0;
    int n_errors = 0;
    int wraps_b  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Behavioural reference: one clock edge of the decoder for instance k.
    task automatic model_step(input int k, input logic r, input logic ld, input logic sc,
                              input logic e, input int in_v, output exp_t x);
        int w;
        w = 0;
        if (r) begin
            m_state[k] = 0;
            m_idx[k]   = 0;
            m_cnt[k]   = 0;
        end else if (ld) begin
            m_idx[k]   = in_v;
            m_cnt[k]   = 0;
            m_state[k] = (SCAN_EN && sc) ? 2 : 1;
        end else if (SCAN_EN) begin
            if (m_state[k] != 2) begin
                if (sc) begin
                    m_state[k] = 2;
                    m_cnt[k]   = 0;
                end
            end else if (!sc) begin
                m_state[k] = 1;
                m_cnt[k]   = 0;
            end else if (m_cnt[k] == dwell[k] - 1) begin
                m_cnt[k] = 0;
                m_idx[k] = (m_idx[k] + 1) % 8;
                w        = (m_idx[k] == 0) ? 1 : 0;
            end else begin
                m_cnt[k]++;
            end
        end
        x.idx   = m_idx[k];
        x.wrap  = w;
        x.lines = (e && m_state[k] != 0) ? (1 << m_idx[k]) : 0;
    endtask

    task automatic step(input logic r, input logic ld, input logic sc, input logic e, input int in_v);
        exp_t ea, eb, pa, pb;
        @(negedge clk);
        rst      = r;
        load     = ld;
        scan     = sc;
        en       = e;
        in_lines = 3'(in_v);
        model_step(0, r, ld, sc, e, in_v, ea);
        q_a.push_back(ea);
        model_step(1, r, ld, sc, e, in_v, eb);
        q_b.push_back(eb);
        @(posedge clk);
        #1;
        pa = q_a.pop_front();
        pb = q_b.pop_front();
        check("a.lines", 32'(out_a), 32'(pa.lines));
        check("a.idx", 32'(idx_a), 32'(pa.idx));
        check("a.wrap", 32'(wrap_a), 32'(pa.wrap));
        check("b.lines", 32'(out_b), 32'(pb.lines));
        check("b.idx", 32'(idx_b), 32'(pb.idx));
        check("b.wrap", 32'(wrap_b), 32'(pb.wrap));
        if (wrap_b) wraps_b++;
    endtask

    initial begin
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check("rst.lines", 32'(out_a), 32'h0);

        // Load 5 and hold.
        step(0, 1, 0, 1, 5);
        check("load5.lines", 32'(out_a), 32'h20);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        check("hold5.lines", 32'(out_b), 32'h20);

        // Load 6 with scan: DWELL=2 sweeps through the wrap.
        step(0, 1, 1, 1, 6);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0);

        // Scan from reset, then drop scan once instance b reaches index 3.
        step(1, 0, 0, 1, 0);
        wraps_b = 0;
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
`ifdef DECODER_SCAN_EN
        check("b.hold3", 32'(idx_b), 32'd3);
        check("b.wraps", 32'(wraps_b), 32'd2);
`else
        check("b.noscan", 32'(idx_b), 32'd0);
        check("b.wraps", 32'(wraps_b), 32'd0);
`endif

        // Output disabled while scanning, then re-enabled.
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);

        // Reset in the middle of a scan at index 4 of instance b.
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);
`ifdef DECODER_SCAN_EN
        check("b.pre_rst", 32'(idx_b), 32'd4);
`endif
        step(1, 0, 1, 1, 0);
        check("b.rst_wrap", 32'(wrap_b), 32'd0);
        step(0, 0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
